// File: rtl/buzzer_alarm_ctrl.sv
// Alarm tone generator: beeps the buzzer in an ON/OFF pattern for a programmed
// number of tick_1hz pulses, then pulses done. stop aborts silently.
module buzzer_alarm_ctrl #(
    parameter int DUR_W    = 6,
    parameter int ON_SEC   = 1,
    parameter int OFF_SEC  = 1,
    parameter int TONE_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic             tick_1k,
    input  logic             start,
    input  logic             stop,
    input  logic [DUR_W-1:0] alarm_dur,
    output logic             buzzer,
    output logic             busy,
    output logic             done
);

    localparam int PH_MAX = (ON_SEC > OFF_SEC) ? ON_SEC : OFF_SEC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TN_W   = $clog2(TONE_DIV + 1);

    localparam logic [PH_W-1:0] ON_LAST   = PH_W'(ON_SEC - 1);
    localparam logic [PH_W-1:0] OFF_LAST  = PH_W'(OFF_SEC - 1);
    localparam logic [TN_W-1:0] TONE_LAST = TN_W'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t            state_q, state_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [TN_W-1:0]   tone_q, tone_d;
    logic              buz_q, buz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            phase_q <= '0;
            tone_q  <= '0;
            buz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            tone_q  <= tone_d;
            buz_q   <= buz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        tone_d  = tone_q;
        buz_d   = buz_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            rem_d   = '0;
            phase_d = '0;
            tone_d  = '0;
            buz_d   = 1'b0;
        end else if (start && (alarm_dur != '0)) begin
            state_d = S_ON;
            rem_d   = alarm_dur;
            phase_d = '0;
            tone_d  = '0;
            buz_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    buz_d = 1'b0;
                end
                S_ON: begin
                    if (tick_1k) begin
                        if (tone_q == TONE_LAST) begin
                            tone_d = '0;
                            buz_d  = ~buz_q;
                        end else begin
                            tone_d = tone_q + TN_W'(1);
                        end
                    end
                    // A second boundary overrides any tone toggle in the same cycle
                    if (tick_1hz) begin
                        if (rem_q != '0) rem_d = rem_q - DUR_W'(1);
                        if (rem_q == DUR_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            buz_d   = 1'b0;
                            phase_d = '0;
                            tone_d  = '0;
                        end else if (phase_q == ON_LAST) begin
                            state_d = S_OFF;
                            phase_d = '0;
                            buz_d   = 1'b0;
                            tone_d  = '0;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end
                S_OFF: begin
                    buz_d = 1'b0;
                    if (tick_1hz) begin
                        if (rem_q != '0) rem_d = rem_q - DUR_W'(1);
                        if (rem_q == DUR_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            phase_d = '0;
                            tone_d  = '0;
                        end else if (phase_q == OFF_LAST) begin
                            state_d = S_ON;
                            phase_d = '0;
                            tone_d  = '0;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    buz_d   = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign buzzer = buz_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_buzzer_alarm_ctrl.sv
// Bench for buzzer_alarm_ctrl: two instances (default and ON_SEC=2/TONE_DIV=3)
// driven in lockstep and checked against an elapsed-seconds reference model.
module tb_buzzer_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, tick_1k, start, stop;
    logic [5:0] alarm_dur;
    logic       buz0, bsy0, dn0, buz1, bsy1, dn1;
    logic [2:0] obs [2];

    int total = 0;
    int bad   = 0;

    // Reference model state: elapsed seconds since start, tone ticks since ON entry
    bit m_act  [2];
    int m_rem  [2];
    int m_el   [2];
    int m_kc   [2];
    bit m_buz  [2];
    bit m_done [2];

    always #5 clk = ~clk;

    buzzer_alarm_ctrl #(.DUR_W(6), .ON_SEC(1), .OFF_SEC(1), .TONE_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_1k(tick_1k),
        .start(start), .stop(stop), .alarm_dur(alarm_dur),
        .buzzer(buz0), .busy(bsy0), .done(dn0)
    );

    buzzer_alarm_ctrl #(.DUR_W(6), .ON_SEC(2), .OFF_SEC(1), .TONE_DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_1k(tick_1k),
        .start(start), .stop(stop), .alarm_dur(alarm_dur),
        .buzzer(buz1), .busy(bsy1), .done(dn1)
    );

    assign obs[0] = {buz0, bsy0, dn0};
    assign obs[1] = {buz1, bsy1, dn1};

    function automatic int on_s(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int off_s(input int k);
        return (k == 0) ? 1 : 1;
    endfunction

    function automatic int tdiv(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [2:0] exp_v(input int k);
        return {m_act[k] && m_buz[k], m_act[k], m_done[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_rem[k] = 0; m_el[k] = 0;
            m_kc[k] = 0; m_buz[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_step(input logic s, input logic st, input logic t1,
                              input logic tk, input logic [5:0] d);
        for (int k = 0; k < 2; k++) begin
            int period;
            bit was_on, now_on;
            period = on_s(k) + off_s(k);
            m_done[k] = 0;
            if (st) begin
                m_act[k] = 0;
                m_buz[k] = 0;
            end else if (s && d != 0) begin
                m_act[k] = 1; m_rem[k] = d; m_el[k] = 0; m_kc[k] = 0; m_buz[k] = 0;
            end else if (m_act[k]) begin
                was_on = (m_el[k] % period) < on_s(k);
                now_on = was_on;
                if (t1) begin
                    m_rem[k]--;
                    m_el[k]++;
                    now_on = (m_el[k] % period) < on_s(k);
                    if (m_rem[k] == 0) begin
                        m_act[k] = 0; m_buz[k] = 0; m_done[k] = 1;
                    end else if (now_on != was_on) begin
                        m_kc[k] = 0; m_buz[k] = 0;
                    end
                end
                if (m_act[k] && was_on && now_on && tk) begin
                    m_kc[k]++;
                    m_buz[k] = ((m_kc[k] / tdiv(k)) % 2) == 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic s, input logic st, input logic t1,
                       input logic tk, input logic [5:0] d);
        start = s; stop = st; tick_1hz = t1; tick_1k = tk; alarm_dur = d;
        @(posedge clk);
        model_step(s, st, t1, tk, d);
        #1;
        start = 0; stop = 0; tick_1hz = 0; tick_1k = 0; alarm_dur = '0;
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 3'b000) begin
                bad++;
                $display("FAIL reset_state dut%0d: got %b want 000", k, obs[k]);
            end
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 6'd10);
        cyc(0, 0, 0, 1, 6'd0);
        total++;
        if (obs[0] !== 3'b110) begin
            bad++;
            $display("FAIL reset_mid_pre: got %b want 110", obs[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 3'b000) begin
                bad++;
                $display("FAIL reset_mid_async dut%0d: got %b want 000", k, obs[k]);
            end
        end
        model_reset();
        #3 rst_n = 1'b1;
        #4;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 6'd0);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== 3'b000) begin
                    bad++;
                    $display("FAIL reset_mid_idle dut%0d: got %b want 000", k, obs[k]);
                end
            end
        end
    endtask

    task automatic test_basic();
        cyc(1, 0, 0, 0, 6'd4);
        total++;
        if (obs[0] !== 3'b010) begin
            bad++;
            $display("FAIL basic_busy: got %b want 010", obs[0]);
        end
        for (int sec = 0; sec < 4; sec++) begin
            int  tog;
            logic prev;
            tog  = 0;
            prev = buz0;
            for (int c = 0; c < 20; c++) begin
                cyc(0, 0, c == 19, (c % 2) == 1, 6'd0);
                if (buz0 !== prev) tog++;
                prev = buz0;
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (obs[k] !== exp_v(k)) begin
                        bad++;
                        $display("FAIL basic_cycle dut%0d sec%0d c%0d: got %b want %b",
                                 k, sec, c, obs[k], exp_v(k));
                    end
                end
            end
            total++;
            if ((tog > 0) !== ((sec % 2) == 0)) begin
                bad++;
                $display("FAIL basic_pattern sec%0d: toggles %0d want on=%0d",
                         sec, tog, (sec % 2) == 0);
            end
        end
        total++;
        if (obs[0] !== 3'b001) begin
            bad++;
            $display("FAIL basic_done: got %b want 001", obs[0]);
        end
        cyc(0, 0, 0, 0, 6'd0);
        total++;
        if (obs[0] !== 3'b000) begin
            bad++;
            $display("FAIL basic_done_pulse: got %b want 000", obs[0]);
        end
    endtask

    task automatic test_tone_div3();
        logic [5:0] pat;
        pat = 6'b011100;
        cyc(1, 0, 0, 0, 6'd3);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, 6'd0);
            total++;
            if (buz1 !== pat[i]) begin
                bad++;
                $display("FAIL tone_div3 tick%0d: got %b want %b", i + 1, buz1, pat[i]);
            end
            total++;
            if (obs[0] !== exp_v(0)) begin
                bad++;
                $display("FAIL tone_div3_dut0 tick%0d: got %b want %b", i + 1, obs[0], exp_v(0));
            end
        end
        cyc(0, 1, 0, 0, 6'd0);
    endtask

    task automatic test_on2();
        logic [4:0] seen;
        seen = '0;
        cyc(1, 0, 0, 0, 6'd5);
        for (int sec = 0; sec < 5; sec++) begin
            for (int c = 0; c < 12; c++) begin
                cyc(0, 0, c == 11, (c % 2) == 1, 6'd0);
                if (buz1 === 1'b1) seen[sec] = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (obs[k] !== exp_v(k)) begin
                        bad++;
                        $display("FAIL on2_cycle dut%0d sec%0d c%0d: got %b want %b",
                                 k, sec, c, obs[k], exp_v(k));
                    end
                end
            end
        end
        total++;
        if (seen !== 5'b11011) begin
            bad++;
            $display("FAIL on2_pattern: got %b want 11011", seen);
        end
        total++;
        if (obs[1] !== 3'b001) begin
            bad++;
            $display("FAIL on2_done: got %b want 001", obs[1]);
        end
    endtask

    task automatic test_stop();
        cyc(1, 0, 0, 0, 6'd6);
        cyc(0, 0, 1, 1, 6'd0);
        cyc(0, 0, 0, 1, 6'd0);
        cyc(0, 0, 1, 1, 6'd0);
        cyc(0, 0, 0, 1, 6'd0);
        cyc(0, 1, 0, 0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== 3'b000) begin
                    bad++;
                    $display("FAIL stop_idle dut%0d step%0d: got %b want 000", k, i, obs[k]);
                end
            end
            cyc(0, 0, 1, 1, 6'd0);
        end
        cyc(1, 0, 0, 0, 6'd6);
        cyc(1, 1, 0, 0, 6'd6);
        total++;
        if (obs[0] !== 3'b000) begin
            bad++;
            $display("FAIL stop_start_busy: got %b want 000", obs[0]);
        end
        cyc(1, 1, 0, 0, 6'd6);
        total++;
        if (obs[1] !== 3'b000) begin
            bad++;
            $display("FAIL stop_start_idle: got %b want 000", obs[1]);
        end
    endtask

    task automatic test_restart();
        cyc(1, 0, 0, 0, 6'd3);
        cyc(0, 0, 1, 0, 6'd0);
        cyc(0, 0, 1, 0, 6'd0);
        cyc(1, 0, 0, 0, 6'd3);
        total++;
        if (obs[0] !== 3'b010) begin
            bad++;
            $display("FAIL restart_busy: got %b want 010", obs[0]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 6'd0);
            total++;
            if (obs[0] !== ((i == 2) ? 3'b001 : 3'b010)) begin
                bad++;
                $display("FAIL restart_tick%0d: got %b want %b", i + 1, obs[0],
                         (i == 2) ? 3'b001 : 3'b010);
            end
        end
        cyc(1, 0, 0, 0, 6'd0);
        cyc(0, 0, 1, 1, 6'd0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 3'b000) begin
                bad++;
                $display("FAIL restart_dur0 dut%0d: got %b want 000", k, obs[k]);
            end
        end
    endtask

    task automatic test_coincide();
        cyc(1, 0, 0, 0, 6'd4);
        cyc(0, 0, 1, 1, 6'd0);
        total++;
        if (obs[0] !== 3'b010) begin
            bad++;
            $display("FAIL coincide_on_off: got %b want 010", obs[0]);
        end
        cyc(0, 1, 0, 0, 6'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            logic       s, st, t1, tk;
            logic [5:0] d;
            s  = ($urandom % 40) == 0;
            st = ($urandom % 150) == 0;
            t1 = ($urandom % 12) == 0;
            tk = ($urandom % 3) == 0;
            d  = 6'($urandom_range(1, 9));
            if (($urandom % 8) == 0) d = '0;
            cyc(s, st, t1, tk, d);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_v(k)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: got %b want %b", k, i, obs[k], exp_v(k));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; stop = 0; tick_1hz = 0; tick_1k = 0; alarm_dur = '0;
        model_reset();
        test_reset();
        test_reset_mid();
        test_basic();
        test_tone_div3();
        test_on2();
        test_stop();
        test_restart();
        test_coincide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
